// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: RV32I load/store funct3 encodings and the
// request FSM states, plus the alignment rule shared by decode logic.
package mem_stage_pkg;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [2:0] {
        Lb  = 3'b000,
        Lh  = 3'b001,
        Lw  = 3'b010,
        Lbu = 3'b100,
        Lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        Sb = 3'b000,
        Sh = 3'b001,
        Sw = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // Byte accesses are never misaligned; halves need addr[0]=0, words addr[1:0]=0.
    function automatic logic addr_misaligned(input logic          is_store,
                                             input store_funct3_t storeop,
                                             input load_funct3_t  loadop,
                                             input logic [1:0]    offset);
        logic bad;
        bad = 1'b0;
        if (is_store) begin
            case (storeop)
                Sh:      bad = offset[0];
                Sw:      bad = |offset;
                default: bad = 1'b0;
            endcase
        end else begin
            case (loadop)
                Lh, Lhu: bad = offset[0];
                Lw:      bad = |offset;
                default: bad = 1'b0;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port between the memory stage (master) and the data cache (slave).
interface mem_stage_if;

    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    modport master (
        output dmem_read,
        output dmem_write,
        output dmem_address,
        output dmem_wdata,
        output dmem_byte_enable,
        input  dmem_rdata,
        input  dmem_resp
    );

    modport slave (
        input  dmem_read,
        input  dmem_write,
        input  dmem_address,
        input  dmem_wdata,
        input  dmem_byte_enable,
        output dmem_rdata,
        output dmem_resp
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Combinational load extractor: selects the byte/half at the given offset of the
// returned word and sign- or zero-extends it according to the load type.
module load_align
    import mem_stage_pkg::*;
(
    input  rv32i_word    rdata_i,
    input  logic [1:0]   offset_i,
    input  load_funct3_t loadop_i,
    output rv32i_word    data_o
);

    rv32i_word   shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (loadop_i)
            Lb:      data_o = {{24{byte_v[7]}}, byte_v};
            Lbu:     data_o = {24'd0, byte_v};
            Lh:      data_o = {{16{half_v[15]}}, half_v};
            Lhu:     data_o = {16'd0, half_v};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues one registered data-memory request per aligned
// load/store, stalls upstream until the response, and extends load data.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          MEM_valid,
    input  logic          MEM_mem_read,
    input  logic          MEM_mem_write,
    input  rv32i_word     MEM_alu_out,
    input  rv32i_word     MEM_rs2_out,
    input  load_funct3_t  MEM_loadop,
    input  store_funct3_t MEM_storeop,
    mem_stage_if.master   dmem,
    output rv32i_word     MEM_load_data,
    output logic          MEM_stall,
    output logic          MEM_misaligned
);

    mem_state_t   state_q, state_d;
    rv32i_word    addr_q, addr_d;
    rv32i_word    wdata_q, wdata_d;
    rv32i_word    load_data_q, load_data_d;
    logic [3:0]   be_q, be_d;
    logic         read_q, read_d;
    logic         write_q, write_d;
    load_funct3_t load_type_q, load_type_d;
    logic [1:0]   offset_q, offset_d;

    logic         is_store;
    logic         memop;
    logic         misalign;
    logic         start;
    logic [1:0]   offset;
    logic [3:0]   st_be;
    rv32i_word    st_wdata;
    rv32i_word    load_word;

    load_align u_load_align (
        .rdata_i  (dmem.dmem_rdata),
        .offset_i (offset_q),
        .loadop_i (load_type_q),
        .data_o   (load_word)
    );

    // A simultaneous read+write is treated as a store.
    always_comb begin
        is_store = MEM_mem_write;
        memop    = MEM_valid & (MEM_mem_read | MEM_mem_write);
        offset   = MEM_alu_out[1:0];
        misalign = addr_misaligned(is_store, MEM_storeop, MEM_loadop, offset);
        start    = (state_q == IDLE) & memop & ~misalign;
        st_be    = 4'b0000;
        st_wdata = '0;
        if (is_store) begin
            case (MEM_storeop)
                Sb: begin
                    st_be    = 4'b0001 << offset;
                    st_wdata = {24'd0, MEM_rs2_out[7:0]} << {offset, 3'b000};
                end
                Sh: begin
                    st_be    = 4'b0011 << offset;
                    st_wdata = {16'd0, MEM_rs2_out[15:0]} << {offset[1], 4'b0000};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = MEM_rs2_out;
                end
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        read_d      = read_q;
        write_d     = write_q;
        load_type_d = load_type_q;
        offset_d    = offset_q;
        load_data_d = load_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = BUSY;
                    addr_d      = {MEM_alu_out[31:2], 2'b00};
                    wdata_d     = st_wdata;
                    be_d        = st_be;
                    read_d      = ~is_store;
                    write_d     = is_store;
                    load_type_d = MEM_loadop;
                    offset_d    = offset;
                end
            end
            BUSY: begin
                if (dmem.dmem_resp) begin
                    state_d = DONE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (read_q) begin
                        load_data_d = load_word;
                    end
                end
            end
            // DONE lets the pipeline advance once; a new request is only taken from IDLE.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= 4'b0000;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            load_type_q <= Lb;
            offset_q    <= 2'b00;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            read_q      <= read_d;
            write_q     <= write_d;
            load_type_q <= load_type_d;
            offset_q    <= offset_d;
            load_data_q <= load_data_d;
        end
    end

    assign dmem.dmem_read        = read_q;
    assign dmem.dmem_write       = write_q;
    assign dmem.dmem_address     = addr_q;
    assign dmem.dmem_wdata       = wdata_q;
    assign dmem.dmem_byte_enable = be_q;
    assign MEM_load_data         = load_data_q;

    // Gated by rst so both strobes read zero while reset is held.
    assign MEM_stall      = ~rst & (start | (state_q == BUSY));
    assign MEM_misaligned = ~rst & (state_q == IDLE) & memop & misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized ops
// against a behavioural model of the load/store rules.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic          clk;
    logic          rst;
    logic          valid, mrd, mwr;
    logic [31:0]   alu, rs2;
    load_funct3_t  loadop;
    store_funct3_t storeop;
    logic [31:0]   load_data;
    logic          stall, misal;

    int checks = 0;
    int failures = 0;
    int req_rises = 0;
    logic req_prev = 1'b0;
    logic [31:0] ld_model = 32'd0;

    mem_stage_if dmem_bus ();

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .MEM_valid      (valid),
        .MEM_mem_read   (mrd),
        .MEM_mem_write  (mwr),
        .MEM_alu_out    (alu),
        .MEM_rs2_out    (rs2),
        .MEM_loadop     (loadop),
        .MEM_storeop    (storeop),
        .dmem           (dmem_bus),
        .MEM_load_data  (load_data),
        .MEM_stall      (stall),
        .MEM_misaligned (misal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((dmem_bus.dmem_read | dmem_bus.dmem_write) && !req_prev) req_rises <= req_rises + 1;
        req_prev <= dmem_bus.dmem_read | dmem_bus.dmem_write;
    end

    // ---------------- reference model ----------------
    function automatic logic m_misal(logic st, logic [2:0] lop, logic [2:0] sop, logic [31:0] a);
        int off = int'(a % 4);
        if (st) return (sop == 3'd2 && off != 0) || (sop == 3'd1 && off % 2 != 0);
        return (lop == 3'd2 && off != 0) || ((lop == 3'd1 || lop == 3'd5) && off % 2 != 0);
    endfunction

    function automatic logic [3:0] m_be(logic [2:0] sop, logic [31:0] a);
        int off = int'(a % 4);
        if (sop == 3'd0) return 4'(1 << off);
        if (sop == 3'd1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_lanes(logic [3:0] be);
        logic [31:0] m = 32'd0;
        for (int k = 0; k < 4; k++) if (be[k]) m = m | (32'hFF << (8 * k));
        return m;
    endfunction

    function automatic logic [31:0] m_wd(logic [2:0] sop, logic [31:0] a, logic [31:0] d);
        int off = int'(a % 4);
        if (sop == 3'd0) return (d & 32'hFF) << (8 * off);
        if (sop == 3'd1) return (d & 32'hFFFF) << (8 * off);
        return d;
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] lop, logic [31:0] a, logic [31:0] rd);
        logic [31:0] sh = rd >> (8 * int'(a % 4));
        logic [31:0] b = sh & 32'hFF;
        logic [31:0] h = sh & 32'hFFFF;
        case (lop)
            3'd0: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd4: return b;
            3'd1: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd5: return h;
            default: return rd;
        endcase
    endfunction

    // Drives one instruction until the pipeline advances (stall low), acting as the
    // memory: responds on the n-th request cycle. Returns what was observed.
    task automatic run_op(input logic v, input logic is_ld, input logic is_st,
                          input logic [31:0] a, input logic [31:0] d, input logic [2:0] lop,
                          input logic [2:0] sop, input logic [31:0] rd, input int n,
                          output int stall_c, output int rd_c, output int wr_c,
                          output int mis_c, output int first_req, output logic [31:0] a_seen,
                          output logic [3:0] be_seen, output logic [31:0] wd_seen,
                          output logic unstable, output logic timeout);
        int   busy = 0;
        logic st_now;
        stall_c = 0; rd_c = 0; wr_c = 0; mis_c = 0; first_req = -1;
        a_seen = '0; be_seen = '0; wd_seen = '0; unstable = 1'b0; timeout = 1'b1;
        valid = v; mrd = is_ld; mwr = is_st; alu = a; rs2 = d;
        loadop = load_funct3_t'(lop); storeop = store_funct3_t'(sop);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            st_now = stall;
            if (stall) stall_c++;
            if (misal) mis_c++;
            if (dmem_bus.dmem_read || dmem_bus.dmem_write) begin
                if (busy == 0) begin
                    first_req = c;
                    a_seen    = dmem_bus.dmem_address;
                    be_seen   = dmem_bus.dmem_byte_enable;
                    wd_seen   = dmem_bus.dmem_wdata;
                end else if (dmem_bus.dmem_address !== a_seen ||
                             dmem_bus.dmem_byte_enable !== be_seen ||
                             dmem_bus.dmem_wdata !== wd_seen) begin
                    unstable = 1'b1;
                end
                busy++;
                if (dmem_bus.dmem_read) rd_c++;
                if (dmem_bus.dmem_write) wr_c++;
                if (busy == n) begin
                    dmem_bus.dmem_resp  = 1'b1;
                    dmem_bus.dmem_rdata = rd;
                end
            end
            @(posedge clk); #1;
            dmem_bus.dmem_resp  = 1'b0;
            dmem_bus.dmem_rdata = $urandom;
            if (!st_now) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; valid = 1'b1; mrd = 1'b1; mwr = 1'b0; alu = 32'h100; rs2 = 32'h5;
        loadop = Lw; storeop = Sw;
        dmem_bus.dmem_resp = 1'b0; dmem_bus.dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (dmem_bus.dmem_read !== 1'b0) begin failures++; $display("FAIL rst_read got=%0b exp=0", dmem_bus.dmem_read); end
        checks++; if (dmem_bus.dmem_write !== 1'b0) begin failures++; $display("FAIL rst_write got=%0b exp=0", dmem_bus.dmem_write); end
        checks++; if (dmem_bus.dmem_address !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", dmem_bus.dmem_address); end
        checks++; if (dmem_bus.dmem_wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", dmem_bus.dmem_wdata); end
        checks++; if (dmem_bus.dmem_byte_enable !== 4'h0) begin failures++; $display("FAIL rst_be got=%h exp=0", dmem_bus.dmem_byte_enable); end
        checks++; if (load_data !== 32'h0) begin failures++; $display("FAIL rst_load_data got=%h exp=0", load_data); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", stall); end
        checks++; if (misal !== 1'b0) begin failures++; $display("FAIL rst_misaligned got=%0b exp=0", misal); end
        valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        ld_model = 32'h0;
    endtask

    task automatic test_store_word();
        int sc, rc, wc, mc, fr; logic [31:0] as, ws; logic [3:0] bs; logic un, to;
        run_op(1'b1, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 3'd0, 3'd2, 32'h0, 3,
               sc, rc, wc, mc, fr, as, bs, ws, un, to);
        valid = 1'b0;
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL sw_timeout got=%0b exp=0", to); end
        checks++; if (as !== 32'h100) begin failures++; $display("FAIL sw_addr got=%h exp=00000100", as); end
        checks++; if (bs !== 4'b1111) begin failures++; $display("FAIL sw_be got=%b exp=1111", bs); end
        checks++; if (ws !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sw_wdata got=%h exp=deadbeef", ws); end
        checks++; if (wc !== 3 || rc !== 0) begin failures++; $display("FAIL sw_held got=%0d/%0d exp=3/0", wc, rc); end
        checks++; if (sc !== 4) begin failures++; $display("FAIL sw_stall got=%0d exp=4", sc); end
        checks++; if (un !== 1'b0) begin failures++; $display("FAIL sw_stable got=%0b exp=0", un); end
        checks++; if (load_data !== ld_model) begin failures++; $display("FAIL sw_keeps_load got=%h exp=%h", load_data, ld_model); end
    endtask

    task automatic test_store_byte();
        int sc, rc, wc, mc, fr; logic [31:0] as, ws; logic [3:0] bs; logic un, to;
        run_op(1'b1, 1'b0, 1'b1, 32'h203, 32'h0000_00A5, 3'd0, 3'd0, 32'h0, 2,
               sc, rc, wc, mc, fr, as, bs, ws, un, to);
        valid = 1'b0;
        checks++; if (as !== 32'h200) begin failures++; $display("FAIL sb_addr got=%h exp=00000200", as); end
        checks++; if (bs !== 4'b1000) begin failures++; $display("FAIL sb_be got=%b exp=1000", bs); end
        checks++; if (ws[31:24] !== 8'hA5) begin failures++; $display("FAIL sb_wdata got=%h exp=a5", ws[31:24]); end
        checks++; if (sc !== 3 || to !== 1'b0) begin failures++; $display("FAIL sb_stall got=%0d exp=3", sc); end
    endtask

    task automatic test_load_extend();
        int sc, rc, wc, mc, fr; logic [31:0] as, ws; logic [3:0] bs; logic un, to;
        run_op(1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 3'd0, 3'd0, 32'h1280_4567, 1,
               sc, rc, wc, mc, fr, as, bs, ws, un, to);
        checks++; if (load_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_sext got=%h exp=ffffff80", load_data); end
        checks++; if (rc !== 1 || as !== 32'h100) begin failures++; $display("FAIL lb_req got=%0d@%h exp=1@00000100", rc, as); end
        run_op(1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 3'd4, 3'd0, 32'h1280_4567, 2,
               sc, rc, wc, mc, fr, as, bs, ws, un, to);
        valid = 1'b0;
        checks++; if (load_data !== 32'h0000_0080) begin failures++; $display("FAIL lbu_zext got=%h exp=00000080", load_data); end
        ld_model = 32'h0000_0080;
    endtask

    task automatic test_misaligned();
        int sc, rc, wc, mc, fr; logic [31:0] as, ws; logic [3:0] bs; logic un, to;
        run_op(1'b1, 1'b1, 1'b0, 32'h101, 32'h0, 3'd2, 3'd0, 32'h1234_5678, 1,
               sc, rc, wc, mc, fr, as, bs, ws, un, to);
        valid = 1'b0;
        checks++; if (mc !== 1) begin failures++; $display("FAIL lw_mis_pulse got=%0d exp=1", mc); end
        checks++; if (rc !== 0 || wc !== 0) begin failures++; $display("FAIL lw_mis_noreq got=%0d exp=0", rc + wc); end
        checks++; if (sc !== 0) begin failures++; $display("FAIL lw_mis_stall got=%0d exp=0", sc); end
        @(negedge clk);
        checks++; if (misal !== 1'b0 || dmem_bus.dmem_read !== 1'b0) begin failures++; $display("FAIL lw_mis_after got=%0b%0b exp=00", misal, dmem_bus.dmem_read); end
        @(posedge clk); #1;
        checks++; if (load_data !== ld_model) begin failures++; $display("FAIL lw_mis_keep got=%h exp=%h", load_data, ld_model); end
    endtask

    task automatic test_back_to_back();
        int sc, rc, wc, mc, fr; logic [31:0] as, ws; logic [3:0] bs; logic un, to;
        int r0; logic [31:0] rd, d;
        rd = $urandom; d = $urandom;
        r0 = req_rises;
        run_op(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 3'd1, 3'd0, rd, 1,
               sc, rc, wc, mc, fr, as, bs, ws, un, to);
        ld_model = m_load(3'd1, 32'h0, rd);
        checks++; if (sc !== 2 || fr !== 1) begin failures++; $display("FAIL b2b_lh got=%0d/%0d exp=2/1", sc, fr); end
        checks++; if (load_data !== ld_model) begin failures++; $display("FAIL b2b_lh_data got=%h exp=%h", load_data, ld_model); end
        run_op(1'b1, 1'b0, 1'b1, 32'h6, d, 3'd0, 3'd1, 32'h0, 1,
               sc, rc, wc, mc, fr, as, bs, ws, un, to);
        valid = 1'b0;
        checks++; if (fr !== 1 || sc !== 2) begin failures++; $display("FAIL b2b_sh_start got=%0d/%0d exp=1/2", fr, sc); end
        checks++; if (as !== 32'h4 || bs !== 4'b1100) begin failures++; $display("FAIL b2b_sh_lane got=%h/%b exp=00000004/1100", as, bs); end
        checks++; if (ws[31:16] !== d[15:0]) begin failures++; $display("FAIL b2b_sh_data got=%h exp=%h", ws[31:16], d[15:0]); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_rises - r0 !== 2) begin failures++; $display("FAIL b2b_reqs got=%0d exp=2", req_rises - r0); end
    endtask

    task automatic test_reset_mid_busy();
        int sc, rc, wc, mc, fr; logic [31:0] as, ws; logic [3:0] bs; logic un, to;
        logic seen = 1'b0;
        valid = 1'b1; mrd = 1'b1; mwr = 1'b0; alu = 32'h40; loadop = Lw;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (dmem_bus.dmem_read) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL rstb_busy got=%0b exp=1", seen); end
        #2 rst = 1'b1;
        #1;
        checks++; if (dmem_bus.dmem_read !== 1'b0 || dmem_bus.dmem_write !== 1'b0) begin failures++; $display("FAIL rstb_drop got=%0b exp=0", dmem_bus.dmem_read); end
        checks++; if (dmem_bus.dmem_address !== 32'h0 || dmem_bus.dmem_byte_enable !== 4'h0 || dmem_bus.dmem_wdata !== 32'h0) begin failures++; $display("FAIL rstb_bus got=%h exp=0", dmem_bus.dmem_address); end
        checks++; if (load_data !== 32'h0 || stall !== 1'b0 || misal !== 1'b0) begin failures++; $display("FAIL rstb_outs got=%h/%0b/%0b exp=0/0/0", load_data, stall, misal); end
        valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        ld_model = 32'h0;
        run_op(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 3'd2, 3'd0, 32'hCAFE_F00D, 2,
               sc, rc, wc, mc, fr, as, bs, ws, un, to);
        valid = 1'b0;
        checks++; if (fr !== 1 || sc !== 3) begin failures++; $display("FAIL rstb_idle got=%0d/%0d exp=1/3", fr, sc); end
        checks++; if (load_data !== 32'hCAFE_F00D) begin failures++; $display("FAIL rstb_lw got=%h exp=cafef00d", load_data); end
        ld_model = 32'hCAFE_F00D;
    endtask

    task automatic test_random();
        int sc, rc, wc, mc, fr; logic [31:0] as, ws; logic [3:0] bs; logic un, to;
        logic [2:0] ltab [5];
        logic v, ld, st, memop, mis; logic [31:0] a, d, rd; logic [2:0] lop, sop; int n, kind;
        ltab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            v  = (kind != 1);
            st = $urandom_range(0, 1);
            ld = ~st | ($urandom_range(0, 9) == 0);
            if (kind == 0) begin ld = 1'b0; st = 1'b0; end
            a   = $urandom; d = $urandom; rd = $urandom;
            lop = ltab[$urandom_range(0, 4)];
            sop = 3'($urandom_range(0, 2));
            n   = $urandom_range(1, 4);
            memop = v & (ld | st);
            mis   = memop & m_misal(st, lop, sop, a);
            run_op(v, ld, st, a, d, lop, sop, rd, n, sc, rc, wc, mc, fr, as, bs, ws, un, to);
            checks++; if (to !== 1'b0) begin failures++; $display("FAIL rnd_timeout op=%0d", i); end
            checks++; if (mc !== int'(mis)) begin failures++; $display("FAIL rnd_mis op=%0d got=%0d exp=%0d", i, mc, mis); end
            if (!memop || mis) begin
                checks++; if (sc !== 0 || rc + wc !== 0) begin failures++; $display("FAIL rnd_pass op=%0d got=%0d/%0d exp=0/0", i, sc, rc + wc); end
            end else begin
                checks++; if (sc !== n + 1) begin failures++; $display("FAIL rnd_stall op=%0d got=%0d exp=%0d", i, sc, n + 1); end
                checks++; if (rc !== (st ? 0 : n) || wc !== (st ? n : 0)) begin failures++; $display("FAIL rnd_strobe op=%0d got=%0d/%0d exp=%0d/%0d", i, rc, wc, st ? 0 : n, st ? n : 0); end
                checks++; if (as !== ((a / 4) * 4) || un !== 1'b0) begin failures++; $display("FAIL rnd_addr op=%0d got=%h exp=%h", i, as, (a / 4) * 4); end
                if (st) begin
                    checks++; if (bs !== m_be(sop, a)) begin failures++; $display("FAIL rnd_be op=%0d got=%b exp=%b", i, bs, m_be(sop, a)); end
                    checks++; if ((ws & m_lanes(m_be(sop, a))) !== m_wd(sop, a, d)) begin failures++; $display("FAIL rnd_wdata op=%0d got=%h exp=%h", i, ws, m_wd(sop, a, d)); end
                end else begin
                    ld_model = m_load(lop, a, rd);
                end
            end
            checks++; if (load_data !== ld_model) begin failures++; $display("FAIL rnd_load op=%0d got=%h exp=%h", i, load_data, ld_model); end
            // Idle gap with an occasional stray response that must be ignored.
            valid = 1'b0;
            dmem_bus.dmem_resp  = ($urandom_range(0, 2) == 0);
            dmem_bus.dmem_rdata = $urandom;
            @(negedge clk);
            checks++; if (stall !== 1'b0 || dmem_bus.dmem_read !== 1'b0 || dmem_bus.dmem_write !== 1'b0) begin failures++; $display("FAIL rnd_idle op=%0d got=%0b%0b%0b exp=000", i, stall, dmem_bus.dmem_read, dmem_bus.dmem_write); end
            @(posedge clk); #1;
            dmem_bus.dmem_resp = 1'b0;
            checks++; if (load_data !== ld_model) begin failures++; $display("FAIL rnd_stray op=%0d got=%h exp=%h", i, load_data, ld_model); end
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_byte();
        test_load_extend();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
